// File: rtl/id_ex_stage_if.sv
// Interface bundling the ID-side inputs and EX-side outputs of the ID/EX stage.
// The master modport is the pipeline/testbench side; the slave modport is the stage itself.
interface id_ex_stage_if #(
    parameter int DATA_W  = 64,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 32
);
    logic [REG_AW-1:0]  id_rs1;
    logic [REG_AW-1:0]  id_rs2;
    logic [REG_AW-1:0]  id_rd;
    logic [DATA_W-1:0]  id_rdata1;
    logic [DATA_W-1:0]  id_rdata2;
    logic [DATA_W-1:0]  id_imm;
    logic               id_regwrite;
    logic               id_memread;
    logic               id_memwrite;
    logic               id_memtoreg;
    logic               id_branch;
    logic               id_alusrc;
    logic [ALUOP_W-1:0] id_aluop;
    logic               flush;
    logic               hold;

    logic [REG_AW-1:0]  ex_rs1;
    logic [REG_AW-1:0]  ex_rs2;
    logic [REG_AW-1:0]  ex_rd;
    logic [DATA_W-1:0]  ex_rdata1;
    logic [DATA_W-1:0]  ex_rdata2;
    logic [DATA_W-1:0]  ex_imm;
    logic               ex_regwrite;
    logic               ex_memread;
    logic               ex_memwrite;
    logic               ex_memtoreg;
    logic               ex_branch;
    logic               ex_alusrc;
    logic [ALUOP_W-1:0] ex_aluop;
    logic               pc_write;
    logic               ifid_write;
    logic [CNT_W-1:0]   bubble_count;

    modport master (
        output id_rs1, id_rs2, id_rd, id_rdata1, id_rdata2, id_imm,
               id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch, id_alusrc,
               id_aluop, flush, hold,
        input  ex_rs1, ex_rs2, ex_rd, ex_rdata1, ex_rdata2, ex_imm,
               ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch, ex_alusrc,
               ex_aluop, pc_write, ifid_write, bubble_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_rd, id_rdata1, id_rdata2, id_imm,
               id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch, id_alusrc,
               id_aluop, flush, hold,
        output ex_rs1, ex_rs2, ex_rd, ex_rdata1, ex_rdata2, ex_imm,
               ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch, ex_alusrc,
               ex_aluop, pc_write, ifid_write, bubble_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// flush/hold handling and a saturating bubble counter.
module id_ex_stage #(
    parameter int DATA_W  = 64,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);

    typedef struct packed {
        logic [REG_AW-1:0]  rs1;
        logic [REG_AW-1:0]  rs2;
        logic [REG_AW-1:0]  rd;
        logic [DATA_W-1:0]  rdata1;
        logic [DATA_W-1:0]  rdata2;
        logic [DATA_W-1:0]  imm;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic               memtoreg;
        logic               branch;
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
    } ex_fields_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ex_fields_t       ex_q;
    ex_fields_t       ex_d;
    ex_fields_t       id_s;
    ex_fields_t       id_bubble_s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             load_use_s;

    // Gather the ID inputs and derive the control-cleared (bubble/flush) variant.
    always_comb begin
        id_s.rs1      = bus.id_rs1;
        id_s.rs2      = bus.id_rs2;
        id_s.rd       = bus.id_rd;
        id_s.rdata1   = bus.id_rdata1;
        id_s.rdata2   = bus.id_rdata2;
        id_s.imm      = bus.id_imm;
        id_s.regwrite = bus.id_regwrite;
        id_s.memread  = bus.id_memread;
        id_s.memwrite = bus.id_memwrite;
        id_s.memtoreg = bus.id_memtoreg;
        id_s.branch   = bus.id_branch;
        id_s.alusrc   = bus.id_alusrc;
        id_s.aluop    = bus.id_aluop;

        id_bubble_s          = id_s;
        id_bubble_s.regwrite = 1'b0;
        id_bubble_s.memread  = 1'b0;
        id_bubble_s.memwrite = 1'b0;
        id_bubble_s.memtoreg = 1'b0;
        id_bubble_s.branch   = 1'b0;
        id_bubble_s.alusrc   = 1'b0;
        id_bubble_s.aluop    = {ALUOP_W{1'b0}};
    end

    // Load in EX whose destination is a nonzero source of the instruction in ID.
    always_comb begin
        load_use_s = ex_q.memread
                   && (ex_q.rd != {REG_AW{1'b0}})
                   && ((ex_q.rd == bus.id_rs1) || (ex_q.rd == bus.id_rs2));
    end

    // Next-state selection: flush beats hold beats load-use beats normal load.
    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (bus.flush) begin
            ex_d = id_bubble_s;
        end else if (bus.hold) begin
            ex_d = ex_q;
        end else if (load_use_s) begin
            ex_d = id_bubble_s;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            ex_d = id_s;
        end
    end

    // Pipeline register and bubble counter with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.ex_rs1       = ex_q.rs1;
    assign bus.ex_rs2       = ex_q.rs2;
    assign bus.ex_rd        = ex_q.rd;
    assign bus.ex_rdata1    = ex_q.rdata1;
    assign bus.ex_rdata2    = ex_q.rdata2;
    assign bus.ex_imm       = ex_q.imm;
    assign bus.ex_regwrite  = ex_q.regwrite;
    assign bus.ex_memread   = ex_q.memread;
    assign bus.ex_memwrite  = ex_q.memwrite;
    assign bus.ex_memtoreg  = ex_q.memtoreg;
    assign bus.ex_branch    = ex_q.branch;
    assign bus.ex_alusrc    = ex_q.alusrc;
    assign bus.ex_aluop     = ex_q.aluop;
    assign bus.bubble_count = cnt_q;

    // PC and IF/ID stall whenever a bubble is needed or the pipe is held downstream.
    assign bus.pc_write   = ~(load_use_s | bus.hold);
    assign bus.ifid_write = ~(load_use_s | bus.hold);

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed self-checking bench for id_ex_stage against a behavioural model.
module tb_id_ex_stage;
    localparam int DATA_W  = 64;
    localparam int REG_AW  = 5;
    localparam int ALUOP_W = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [REG_AW-1:0]  rs1, rs2, rd;
        logic [DATA_W-1:0]  rdata1, rdata2, imm;
        logic               regwrite, memread, memwrite, memtoreg, branch, alusrc;
        logic [ALUOP_W-1:0] aluop;
    } ex_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    ex_t  m;
    int   m_cnt;

    id_ex_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic ex_t dut_vec();
        return {bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_rdata1, bus.ex_rdata2, bus.ex_imm,
                bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg,
                bus.ex_branch, bus.ex_alusrc, bus.ex_aluop};
    endfunction

    function automatic ex_t id_vec();
        return {bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_rdata1, bus.id_rdata2, bus.id_imm,
                bus.id_regwrite, bus.id_memread, bus.id_memwrite, bus.id_memtoreg,
                bus.id_branch, bus.id_alusrc, bus.id_aluop};
    endfunction

    // Reference: does the instruction sitting in ID depend on a load sitting in EX?
    function automatic bit model_lu();
        return m.memread && (m.rd != 0) && ((m.rd == bus.id_rs1) || (m.rd == bus.id_rs2));
    endfunction

    function automatic ex_t kill_ctrl(input ex_t e);
        ex_t r = e;
        r.regwrite = 0; r.memread = 0; r.memwrite = 0; r.memtoreg = 0;
        r.branch = 0; r.alusrc = 0; r.aluop = 0;
        return r;
    endfunction

    // Advance one clock, updating the reference model from the inputs presented.
    task automatic step();
        ex_t nxt = m;
        int  nc  = m_cnt;
        if (reset) begin
            nxt = '0; nc = 0;
        end else if (bus.flush) begin
            nxt = kill_ctrl(id_vec());
        end else if (bus.hold) begin
            nxt = m;
        end else if (model_lu()) begin
            nxt = kill_ctrl(id_vec());
            nc  = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end else begin
            nxt = id_vec();
        end
        @(posedge clk);
        #1;
        m = nxt;
        m_cnt = nc;
    endtask

    task automatic clear_id();
        bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
        bus.id_rdata1 = 0; bus.id_rdata2 = 0; bus.id_imm = 0;
        bus.id_regwrite = 0; bus.id_memread = 0; bus.id_memwrite = 0;
        bus.id_memtoreg = 0; bus.id_branch = 0; bus.id_alusrc = 0; bus.id_aluop = 0;
        bus.flush = 0; bus.hold = 0;
    endtask

    task automatic rand_id(input int amax);
        bus.id_rs1 = REG_AW'($urandom_range(amax)); bus.id_rs2 = REG_AW'($urandom_range(amax));
        bus.id_rd  = REG_AW'($urandom_range(amax));
        bus.id_rdata1 = {$urandom, $urandom}; bus.id_rdata2 = {$urandom, $urandom};
        bus.id_imm = {$urandom, $urandom};
        bus.id_regwrite = 1'($urandom); bus.id_memread = 1'($urandom); bus.id_memwrite = 1'($urandom);
        bus.id_memtoreg = 1'($urandom); bus.id_branch = 1'($urandom); bus.id_alusrc = 1'($urandom);
        bus.id_aluop = ALUOP_W'($urandom);
    endtask

    task automatic test_reset();
        rand_id(31);
        bus.id_rd = 5'd9; bus.id_rs1 = 5'd3; bus.id_regwrite = 1; bus.id_memread = 1;
        bus.flush = 0; bus.hold = 0;
        reset = 1;
        step();
        step();
        checks++;
        if (dut_vec() !== ex_t'(0)) begin
            errors++; $display("FAIL reset_ex: got %h expected 0", dut_vec());
        end
        checks++;
        if (bus.bubble_count !== 0) begin
            errors++; $display("FAIL reset_cnt: got %0d expected 0", bus.bubble_count);
        end
        reset = 0;
        clear_id();
        #1;
        checks++;
        if (bus.pc_write !== 1'b1 || bus.ifid_write !== 1'b1) begin
            errors++; $display("FAIL reset_pcw: got %b/%b expected 1/1", bus.pc_write, bus.ifid_write);
        end
    endtask

    task automatic test_normal();
        clear_id();
        bus.id_rd = 5'd5; bus.id_rdata1 = 64'h10; bus.id_imm = 64'hFFFF_FFFF_FFFF_FFF8;
        bus.id_regwrite = 1; bus.id_aluop = 4'b0010;
        step();
        checks++;
        if (bus.ex_rd !== 5'd5 || bus.ex_rdata1 !== 64'h10 || bus.ex_imm !== 64'hFFFF_FFFF_FFFF_FFF8
            || bus.ex_regwrite !== 1'b1 || bus.ex_aluop !== 4'b0010) begin
            errors++; $display("FAIL normal_fields: got rd=%0d d1=%h imm=%h rw=%b op=%b expected 5/10/fff8/1/0010",
                                bus.ex_rd, bus.ex_rdata1, bus.ex_imm, bus.ex_regwrite, bus.ex_aluop);
        end
        checks++;
        if (dut_vec() !== m) begin
            errors++; $display("FAIL normal_vec: got %h expected %h", dut_vec(), m);
        end
    endtask

    task automatic test_load_use();
        int c0 = m_cnt;
        clear_id();
        bus.id_memread = 1; bus.id_rd = 5'd7; bus.id_regwrite = 1;
        step();
        clear_id();
        bus.id_rs2 = 5'd7; bus.id_rd = 5'd8; bus.id_regwrite = 1; bus.id_rdata2 = 64'hABCD;
        #1;
        checks++;
        if (bus.pc_write !== 1'b0 || bus.ifid_write !== 1'b0) begin
            errors++; $display("FAIL lu_stall: got %b/%b expected 0/0", bus.pc_write, bus.ifid_write);
        end
        step();
        checks++;
        if (bus.ex_regwrite !== 1'b0 || bus.ex_memread !== 1'b0 || bus.bubble_count !== CNT_W'(c0 + 1)) begin
            errors++; $display("FAIL lu_bubble: got rw=%b mr=%b cnt=%0d expected 0/0/%0d",
                                bus.ex_regwrite, bus.ex_memread, bus.bubble_count, c0 + 1);
        end
        checks++;
        if (bus.pc_write !== 1'b1) begin
            errors++; $display("FAIL lu_release: got %b expected 1", bus.pc_write);
        end
        step();
        checks++;
        if (bus.ex_regwrite !== 1'b1 || bus.ex_rs2 !== 5'd7 || bus.ex_rdata2 !== 64'hABCD) begin
            errors++; $display("FAIL lu_dependent: got rw=%b rs2=%0d d2=%h expected 1/7/abcd",
                                bus.ex_regwrite, bus.ex_rs2, bus.ex_rdata2);
        end
    endtask

    task automatic test_rd_zero();
        int c0 = m_cnt;
        clear_id();
        bus.id_memread = 1; bus.id_rd = 5'd0;
        step();
        clear_id();
        bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
        #1;
        checks++;
        if (bus.pc_write !== 1'b1) begin
            errors++; $display("FAIL rd0_stall: got %b expected 1", bus.pc_write);
        end
        step();
        checks++;
        if (bus.bubble_count !== CNT_W'(c0)) begin
            errors++; $display("FAIL rd0_cnt: got %0d expected %0d", bus.bubble_count, c0);
        end
    endtask

    task automatic test_hold();
        ex_t frozen;
        ex_t pre;
        int  c0;
        clear_id();
        rand_id(31);
        bus.id_memread = 0;
        step();
        frozen = m;
        c0 = m_cnt;
        for (int i = 0; i < 3; i++) begin
            rand_id(31);
            bus.hold = 1;
            #1;
            checks++;
            if (bus.pc_write !== 1'b0 || bus.ifid_write !== 1'b0) begin
                errors++; $display("FAIL hold_pcw%0d: got %b/%b expected 0/0", i, bus.pc_write, bus.ifid_write);
            end
            step();
            checks++;
            if (dut_vec() !== frozen || bus.bubble_count !== CNT_W'(c0)) begin
                errors++; $display("FAIL hold_frozen%0d: got %h expected %h", i, dut_vec(), frozen);
            end
        end
        bus.hold = 0;
        rand_id(31);
        bus.id_rs1 = 0; bus.id_rs2 = 0;
        pre = id_vec();
        step();
        checks++;
        if (dut_vec() !== pre) begin
            errors++; $display("FAIL hold_release: got %h expected %h", dut_vec(), pre);
        end
    endtask

    task automatic test_flush_load_use();
        int c0;
        clear_id();
        bus.id_memread = 1; bus.id_rd = 5'd3;
        step();
        c0 = m_cnt;
        clear_id();
        bus.id_rs1 = 5'd3; bus.id_rd = 5'd12; bus.id_regwrite = 1; bus.id_branch = 1;
        bus.id_aluop = 4'hF; bus.flush = 1;
        #1;
        checks++;
        if (bus.pc_write !== 1'b0) begin
            errors++; $display("FAIL flush_pcw: got %b expected 0", bus.pc_write);
        end
        step();
        checks++;
        if (bus.ex_regwrite !== 0 || bus.ex_branch !== 0 || bus.ex_aluop !== 0 || bus.ex_rd !== 5'd12
            || bus.bubble_count !== CNT_W'(c0)) begin
            errors++; $display("FAIL flush_lu: got rw=%b br=%b op=%h rd=%0d cnt=%0d expected 0/0/0/12/%0d",
                                bus.ex_regwrite, bus.ex_branch, bus.ex_aluop, bus.ex_rd, bus.bubble_count, c0);
        end
        bus.flush = 0;
    endtask

    task automatic test_saturation();
        clear_id();
        bus.id_memread = 1; bus.id_rd = 5'd1; bus.id_rs1 = 5'd1;
        for (int i = 0; i < 2 * (CNT_MAX + 4); i++) step();
        checks++;
        if (bus.bubble_count !== CNT_W'(CNT_MAX) || m_cnt != CNT_MAX) begin
            errors++; $display("FAIL sat_cnt: got %0d expected %0d", bus.bubble_count, CNT_MAX);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        reset = 1; step(); reset = 0;
        c0 = m_cnt;
        for (int k = 0; k < 2; k++) begin
            clear_id();
            bus.id_memread = 1; bus.id_rd = 5'd4; bus.id_rs1 = 5'd4;
            step();
            step();
        end
        checks++;
        if (bus.bubble_count !== CNT_W'(c0 + 2)) begin
            errors++; $display("FAIL b2b_cnt: got %0d expected %0d", bus.bubble_count, c0 + 2);
        end
    endtask

    task automatic test_reset_mid_stall();
        clear_id();
        bus.id_memread = 1; bus.id_rd = 5'd6;
        step();
        bus.id_rs1 = 5'd6;
        reset = 1;
        step();
        reset = 0;
        #1;
        checks++;
        if (dut_vec() !== ex_t'(0) || bus.bubble_count !== 0 || bus.pc_write !== 1'b1) begin
            errors++; $display("FAIL rst_stall: got %h cnt=%0d pcw=%b expected 0/0/1",
                                dut_vec(), bus.bubble_count, bus.pc_write);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_id(3);
            bus.flush = ($urandom_range(9) == 0);
            bus.hold  = ($urandom_range(6) == 0);
            reset     = ($urandom_range(40) == 0);
            #1;
            checks++;
            if (bus.pc_write !== !(model_lu() || bus.hold) || bus.ifid_write !== bus.pc_write) begin
                errors++; $display("FAIL rand_pcw%0d: got %b/%b expected %b", i, bus.pc_write,
                                    bus.ifid_write, !(model_lu() || bus.hold));
            end
            step();
            checks++;
            if (dut_vec() !== m || bus.bubble_count !== CNT_W'(m_cnt)) begin
                errors++; $display("FAIL rand_state%0d: got %h cnt=%0d expected %h cnt=%0d",
                                    i, dut_vec(), bus.bubble_count, m, m_cnt);
            end
        end
        reset = 0;
    endtask

    initial begin
        m = '0;
        m_cnt = 0;
        reset = 1;
        clear_id();
        test_reset();
        test_normal();
        test_load_use();
        test_rd_zero();
        test_hold();
        test_flush_load_use();
        test_saturation();
        test_flush_load_use();
        test_back_to_back();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
